fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Parametrised instruction-fetch front end; replaces the single-cycle "ireq.addr = pc" path in core.
- Owns the architectural fetch PC and drives the ibus with a valid/addr_ok/data_ok handshake, one request outstanding.
- Queues fetched {pc, instr} pairs in a DEPTH-entry FIFO that decode consumes with a valid/ready handshake.
- Supports redirect (branch/jump/flush) with correct discard of an in-flight response.

Parameters:
- RESET_PC, 64'h8000_0000, fetch PC after reset.
- DEPTH, 4, FIFO entries (power of two, 2..16).
- PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ireq  out  ibus_req_t  fields used: valid, addr (64); all other fields driven 0.
- iresp  in  ibus_resp_t  fields used: addr_ok, data_ok, data (32).
- redirect_valid  in  1  load new PC this cycle.
- redirect_pc  in  64  target PC; bits [1:0] ignored and treated as 0.
- out_valid  out  1  FIFO head holds an instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_pc  out  64  PC of head.
- out_instr  out  32  instruction word of head.
- count  out  PTR_W+1  occupied entries, 0..DEPTH.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, FIFO empty (count=0, out_valid=0), state=IDLE, ireq.valid=0. out_pc/out_instr read as 0 while empty.
- States:
  - IDLE: no request pending.
  - REQ: ireq.valid=1, waiting for addr_ok/data_ok.
  - DROP: request pending whose data must be discarded.
- Issue rule: IDLE goes to REQ when count + (pop this cycle ? -1 : 0) < DEPTH, i.e. a slot is reserved for the response. ireq.valid rises the next cycle with ireq.addr=pc.
- In REQ/DROP: ireq.valid and ireq.addr are held stable until data_ok. addr_ok is informational only.
- REQ + data_ok: push {pc, iresp.data}; pc <= pc+4. Go to REQ again (back-to-back, valid stays 1) if a slot remains after this push and pop; otherwise go to IDLE.
- Minimum latency: data_ok in cycle N makes out_valid=1 in cycle N+1.
- Redirect (highest priority), in the same cycle:
  - FIFO is flushed (count=0, out_valid=0 next cycle); a concurrent pop is ignored.
  - pc <= {redirect_pc[63:2], 2'b00}.
  - From IDLE: go to IDLE; issue from the new pc next cycle.
  - From REQ without data_ok: go to DROP.
  - From REQ with data_ok: data discarded; go to IDLE.
  - From DROP: stay in DROP and keep the latest redirect_pc.
- DROP + data_ok: discard the data, no push, no pc increment; go to IDLE.
- FIFO:
  - Circular buffer, read/write pointers wrap modulo DEPTH.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop: count unchanged.
  - A push when full cannot occur by the issue rule; the bench asserts this.
- out_valid depends only on registered state, with no combinational path from out_ready. ireq has no combinational path from iresp.
- PC arithmetic is 64-bit and wraps modulo 2^64.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (64), perf_dropped (64) and perf_stall (64), all reset to 0.
  - perf_fetched increments per push.
  - perf_dropped increments per discarded data_ok, including flushed FIFO entries counted as one per redirect.
  - perf_stall increments each cycle in IDLE with count==DEPTH.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait bus (addr_ok=data_ok=1 the cycle after valid), out_ready=1 -> ireq.addr sequence 8000_0000, 8000_0004, 8000_0008; out_pc trails by one cycle, out_instr matches the memory model.
- out_ready=0, DEPTH=4 -> exactly 4 pushes, count=4, ireq.valid drops to 0. Raise out_ready for one cycle -> one pop, new request, count returns to 4; FIFO order preserved across pointer wrap.
- Bus with 3-cycle data_ok, redirect to 8000_1002 one cycle after issue -> ireq.addr held at the old value until data_ok, that data not pushed, next ireq.addr=8000_1000, out_pc of first delivered = 8000_1000.
- Redirect in the same cycle as data_ok and out_ready with FIFO holding 2 entries -> count=0 next cycle, no stale pc appears on out_pc, next fetch at the redirect target.
- Assert reset low mid-REQ with 3 entries queued -> immediately out_valid=0, ireq.valid=0; after release, fetch restarts at 8000_0000.
- FETCH_PERF_EN build, 10 fetches then one redirect during DROP -> perf_fetched=10, perf_dropped=1, perf_stall matches the cycles spent full.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch front end with one outstanding ibus request and a DEPTH-entry {pc, instr} queue.
// Define FETCH_PERF_EN to add the perf_fetched / perf_dropped / perf_stall counters.

package fetch_buffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic        we;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          DEPTH    = 4,
    localparam int         PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output ibus_req_t        ireq,
    input  ibus_resp_t       iresp,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0]      perf_fetched,
    output logic [63:0]      perf_dropped,
    output logic [63:0]      perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_e;

    localparam logic [PTR_W:0] FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] FULL_M1 = (PTR_W + 1)'(DEPTH - 1);

    state_e               state_q, state_d;
    logic [63:0]          pc_q, pc_d;
    logic [63:0]          addr_q, addr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;

    logic [63:0]          mem_pc_q    [DEPTH];
    logic [31:0]          mem_instr_q [DEPTH];

    logic                 pop;
    logic                 push;
    logic                 drop_data;
    logic [PTR_W:0]       count_pop;
    logic [63:0]          target_pc;
    logic [63:0]          pc_next;

    // addr_ok only acknowledges the address phase; the low redirect bits are forced to zero.
    logic                 unused_inputs;
    assign unused_inputs = ^{iresp.addr_ok, redirect_pc[1:0]};

    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign target_pc = {redirect_pc[63:2], 2'b00};
    assign pc_next   = pc_q + 64'd4;

    // A redirect flushes the queue, so a pop in the same cycle has no effect.
    assign pop       = out_valid & out_ready & ~redirect_valid;
    assign count_pop = count_q - {{PTR_W{1'b0}}, pop};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        push      = 1'b0;
        drop_data = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = target_pc;
                end else if (count_pop < FULL) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end

            REQ: begin
                if (iresp.data_ok) begin
                    if (redirect_valid) begin
                        drop_data = 1'b1;
                        pc_d      = target_pc;
                        state_d   = IDLE;
                    end else begin
                        push = 1'b1;
                        pc_d = pc_next;
                        // Keep the bus busy only while the response after this one still has a slot.
                        if (count_pop < FULL_M1) begin
                            state_d = REQ;
                            addr_d  = pc_next;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                    pc_d    = target_pc;
                end
            end

            DROP: begin
                if (redirect_valid) begin
                    pc_d = target_pc;
                end
                if (iresp.data_ok) begin
                    drop_data = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_pop + (PTR_W + 1)'(push);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: queue storage is not reset; an entry is only visible after it is written, and the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_instr_q[wr_ptr_q] <= iresp.data;
        end
    end

    assign out_pc    = out_valid ? mem_pc_q[rd_ptr_q]    : 64'd0;
    assign out_instr = out_valid ? mem_instr_q[rd_ptr_q] : 32'd0;

    // The request is a pure function of registered state, so there is no path from iresp to ireq.
    always_comb begin
        ireq       = '0;
        ireq.valid = (state_q != IDLE);
        ireq.addr  = addr_q;
    end

`ifdef FETCH_PERF_EN
    logic [63:0] fetched_q, fetched_d;
    logic [63:0] dropped_q, dropped_d;
    logic [63:0] stall_q, stall_d;
    logic        flush_nonempty;
    logic        stalled;

    assign flush_nonempty = redirect_valid & out_valid;
    assign stalled        = (state_q == IDLE) & (count_q == FULL);

    always_comb begin
        fetched_d = fetched_q + 64'(push);
        dropped_d = dropped_q + 64'(drop_data) + 64'(flush_nonempty);
        stall_d   = stall_q + 64'(stalled);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            dropped_q <= dropped_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus a randomized run against a queue-based reference model.
// With FETCH_PERF_EN defined the perf counters are connected and checked as well.

module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          PTR_W    = $clog2(DEPTH);
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic             clk;
    logic             reset;
    ibus_req_t        ireq;
    ibus_resp_t       iresp;
    logic             redirect_valid;
    logic [63:0]      redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_pc;
    logic [31:0]      out_instr;
    logic [PTR_W:0]   count;
`ifdef FETCH_PERF_EN
    logic [63:0]      perf_fetched;
    logic [63:0]      perf_dropped;
    logic [63:0]      perf_stall;
`endif

    fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .count          (count)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the queue holds the PCs decode should see, in order.
    logic [63:0] q_pc [$];
    int          m_pend;   // 0 none, 1 live request, 2 request to be discarded
    logic [63:0] m_pc;
    logic [63:0] m_addr;
    logic [63:0] m_fetched;
    logic [63:0] m_dropped;
    logic [63:0] m_stall;
    int          bus_lat;
    int          bus_wait;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] exp_head_pc();
        return (q_pc.size() != 0) ? q_pc[0] : 64'd0;
    endfunction

    function automatic logic [31:0] exp_head_instr();
        return (q_pc.size() != 0) ? mem_word(q_pc[0]) : 32'd0;
    endfunction

    task automatic model_reset();
        q_pc.delete();
        m_pend    = 0;
        m_pc      = RESET_PC;
        m_addr    = RESET_PC;
        m_fetched = '0;
        m_dropped = '0;
        m_stall   = '0;
        bus_wait  = 0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        iresp          = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Drives one cycle of inputs (bus response derived from the current request), advances the model, returns at the next negedge.
    task automatic tick(input logic rv, input logic [63:0] rpc, input logic rdy);
        logic        dok;
        int          n;
        int          popi;
        logic [63:0] tgt;
        tgt = {rpc[63:2], 2'b00};
        dok = 1'b0;
        if (ireq.valid) begin
            if (bus_wait >= bus_lat) begin
                dok      = 1'b1;
                bus_wait = 0;
            end else begin
                bus_wait++;
            end
        end else begin
            bus_wait = 0;
        end
        iresp.addr_ok  = ireq.valid;
        iresp.data_ok  = dok;
        iresp.data     = dok ? mem_word(ireq.addr) : $urandom;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;

        n    = q_pc.size();
        popi = (n != 0 && rdy && !rv) ? 1 : 0;
        if (m_pend == 0 && n == DEPTH) m_stall++;
        if (rv && n != 0) m_dropped++;
        if (popi == 1) void'(q_pc.pop_front());
        if (rv) q_pc.delete();
        case (m_pend)
            0: begin
                if (rv) m_pc = tgt;
                else if (n - popi < DEPTH) begin
                    m_pend = 1;
                    m_addr = m_pc;
                end
            end
            1: begin
                if (dok) begin
                    if (rv) begin
                        m_dropped++;
                        m_pc   = tgt;
                        m_pend = 0;
                    end else begin
                        q_pc.push_back(m_pc);
                        m_fetched++;
                        m_pc = m_pc + 64'd4;
                        if (n - popi + 1 < DEPTH) m_addr = m_pc;
                        else m_pend = 0;
                    end
                end else if (rv) begin
                    m_pend = 2;
                    m_pc   = tgt;
                end
            end
            default: begin
                if (rv) m_pc = tgt;
                if (dok) begin
                    m_dropped++;
                    m_pend = 0;
                end
            end
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    // A response while the queue is full would overflow it; the issue rule must make that impossible.
    always @(posedge clk) begin
        if (reset === 1'b1 && ireq.valid === 1'b1 && iresp.data_ok === 1'b1) begin
            total++;
            if (count >= DEPTH) begin
                bad++;
                $display("FAIL push_when_full: count=%0d with data_ok pending", count);
            end
        end
    end

    task automatic test_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        iresp          = '0;
        bus_lat        = 0;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (ireq.valid !== 1'b0) begin bad++; $display("FAIL reset_ireq_valid: got %b want 0", ireq.valid); end
        total++; if (out_pc !== 64'd0 || out_instr !== 32'd0) begin bad++; $display("FAIL reset_out_data: got %h/%h want 0/0", out_pc, out_instr); end
        reset = 1'b1;
        model_reset();
        tick(1'b0, '0, 1'b0);
        total++; if (ireq.valid !== 1'b1 || ireq.addr !== RESET_PC) begin bad++; $display("FAIL reset_first_req: got %b/%h want 1/%h", ireq.valid, ireq.addr, RESET_PC); end
        total++; if ({ireq.size, ireq.we, ireq.wstrb, ireq.wdata} !== '0) begin bad++; $display("FAIL ireq_unused_fields: got %h want 0", {ireq.size, ireq.we, ireq.wstrb, ireq.wdata}); end
    endtask

    task automatic test_stream();
        logic [63:0] e;
        do_reset();
        bus_lat = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(1'b0, '0, 1'b1);
            e = RESET_PC + 64'(4 * (k - 1));
            total++; if (ireq.valid !== 1'b1 || ireq.addr !== e) begin bad++; $display("FAIL stream_addr k=%0d: got %b/%h want 1/%h", k, ireq.valid, ireq.addr, e); end
            if (k >= 2) begin
                e = RESET_PC + 64'(4 * (k - 2));
                total++; if (out_valid !== 1'b1 || out_pc !== e) begin bad++; $display("FAIL stream_out_pc k=%0d: got %b/%h want 1/%h", k, out_valid, out_pc, e); end
                total++; if (out_instr !== mem_word(e)) begin bad++; $display("FAIL stream_out_instr k=%0d: got %h want %h", k, out_instr, mem_word(e)); end
                total++; if (count !== (PTR_W + 1)'(1)) begin bad++; $display("FAIL stream_count k=%0d: got %0d want 1", k, count); end
            end
        end
    endtask

    task automatic test_fill_wrap();
        logic [63:0] nxt;
        logic        rdy;
        do_reset();
        bus_lat = 0;
        repeat (8) tick(1'b0, '0, 1'b0);
        total++; if (count !== (PTR_W + 1)'(DEPTH) || ireq.valid !== 1'b0) begin bad++; $display("FAIL fill_full: got count=%0d valid=%b want %0d/0", count, ireq.valid, DEPTH); end
        total++; if (out_pc !== RESET_PC) begin bad++; $display("FAIL fill_head: got %h want %h", out_pc, RESET_PC); end
        tick(1'b0, '0, 1'b1);
        total++; if (count !== (PTR_W + 1)'(DEPTH - 1) || ireq.valid !== 1'b1 || ireq.addr !== RESET_PC + 64'd16) begin
            bad++; $display("FAIL fill_one_pop: got count=%0d valid=%b addr=%h want 3/1/%h", count, ireq.valid, ireq.addr, RESET_PC + 64'd16);
        end
        tick(1'b0, '0, 1'b0);
        total++; if (count !== (PTR_W + 1)'(DEPTH) || ireq.valid !== 1'b0) begin bad++; $display("FAIL fill_refull: got count=%0d valid=%b want %0d/0", count, ireq.valid, DEPTH); end
        nxt = RESET_PC + 64'd4;
        for (int i = 0; i < 24; i++) begin
            rdy = (i % 3) != 2;
            if (out_valid && rdy) begin
                total++; if (out_pc !== nxt || out_instr !== mem_word(nxt)) begin bad++; $display("FAIL wrap_order i=%0d: got %h/%h want %h/%h", i, out_pc, out_instr, nxt, mem_word(nxt)); end
                nxt = nxt + 64'd4;
            end
            tick(1'b0, '0, rdy);
        end
        total++; if (nxt < RESET_PC + 64'd40) begin bad++; $display("FAIL wrap_progress: got next=%h want >= %h", nxt, RESET_PC + 64'd40); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        bus_lat = 3;
        tick(1'b0, '0, 1'b1);
        tick(1'b1, 64'h8000_1002, 1'b1);
        for (int i = 0; i < 8 && ireq.valid; i++) begin
            total++; if (ireq.addr !== RESET_PC || count !== '0) begin bad++; $display("FAIL drop_hold i=%0d: got addr=%h count=%0d want %h/0", i, ireq.addr, count, RESET_PC); end
            tick(1'b0, '0, 1'b1);
        end
        total++; if (ireq.valid !== 1'b0 || count !== '0) begin bad++; $display("FAIL drop_done: got valid=%b count=%0d want 0/0", ireq.valid, count); end
        tick(1'b0, '0, 1'b1);
        total++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_1000) begin bad++; $display("FAIL drop_next_addr: got %b/%h want 1/8000_1000", ireq.valid, ireq.addr); end
        for (int i = 0; i < 8 && !out_valid; i++) tick(1'b0, '0, 1'b0);
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_1000 || out_instr !== mem_word(64'h8000_1000)) begin
            bad++; $display("FAIL drop_first_out: got %b/%h/%h want 1/8000_1000/%h", out_valid, out_pc, out_instr, mem_word(64'h8000_1000));
        end
    endtask

    task automatic test_redirect_dataok();
        do_reset();
        bus_lat = 0;
        repeat (3) tick(1'b0, '0, 1'b0);
        total++; if (count !== (PTR_W + 1)'(2) || ireq.valid !== 1'b1) begin bad++; $display("FAIL rdok_setup: got count=%0d valid=%b want 2/1", count, ireq.valid); end
        tick(1'b1, 64'h9000_0042, 1'b1);
        total++; if (count !== '0 || out_valid !== 1'b0 || out_pc !== 64'd0 || ireq.valid !== 1'b0) begin
            bad++; $display("FAIL rdok_flush: got count=%0d valid=%b pc=%h req=%b want 0/0/0/0", count, out_valid, out_pc, ireq.valid);
        end
        tick(1'b0, '0, 1'b0);
        total++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h9000_0040) begin bad++; $display("FAIL rdok_next_addr: got %b/%h want 1/9000_0040", ireq.valid, ireq.addr); end
        tick(1'b0, '0, 1'b0);
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h9000_0040 || out_instr !== mem_word(64'h9000_0040)) begin
            bad++; $display("FAIL rdok_first_out: got %b/%h/%h want 1/9000_0040/%h", out_valid, out_pc, out_instr, mem_word(64'h9000_0040));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_lat = 2;
        for (int i = 0; i < 40 && count != 3; i++) tick(1'b0, '0, 1'b0);
        total++; if (count !== (PTR_W + 1)'(3) || ireq.valid !== 1'b1) begin bad++; $display("FAIL rmid_setup: got count=%0d valid=%b want 3/1", count, ireq.valid); end
        #2;
        reset = 1'b0;
        iresp = '0;
        #1;
        total++; if (out_valid !== 1'b0 || ireq.valid !== 1'b0 || count !== '0) begin
            bad++; $display("FAIL rmid_async: got valid=%b req=%b count=%0d want 0/0/0", out_valid, ireq.valid, count);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        tick(1'b0, '0, 1'b1);
        total++; if (ireq.valid !== 1'b1 || ireq.addr !== RESET_PC) begin bad++; $display("FAIL rmid_restart: got %b/%h want 1/%h", ireq.valid, ireq.addr, RESET_PC); end
    endtask

    task automatic test_random();
        logic        rv;
        logic        rdy;
        logic [63:0] rpc;
        logic [PTR_W:0] ecnt;
        do_reset();
        bus_lat = 1;
        for (int i = 0; i < 500; i++) begin
            if (!ireq.valid && $urandom_range(0, 15) == 0) bus_lat = $urandom_range(0, 3);
            rv = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else rpc = {$urandom, $urandom};
            rdy = ($urandom_range(0, 2) != 0);
            tick(rv, rpc, rdy);
            ecnt = (PTR_W + 1)'(q_pc.size());
            total++; if (count !== ecnt || out_valid !== (q_pc.size() != 0)) begin bad++; $display("FAIL rnd_count i=%0d: got %0d/%b want %0d/%b", i, count, out_valid, ecnt, q_pc.size() != 0); end
            total++; if (out_pc !== exp_head_pc() || out_instr !== exp_head_instr()) begin
                bad++; $display("FAIL rnd_head i=%0d: got %h/%h want %h/%h", i, out_pc, out_instr, exp_head_pc(), exp_head_instr());
            end
            total++; if (ireq.valid !== (m_pend != 0)) begin bad++; $display("FAIL rnd_req_valid i=%0d: got %b want %b", i, ireq.valid, m_pend != 0); end
            if (m_pend != 0) begin
                total++; if (ireq.addr !== m_addr) begin bad++; $display("FAIL rnd_req_addr i=%0d: got %h want %h", i, ireq.addr, m_addr); end
            end
        end
`ifdef FETCH_PERF_EN
        total++; if (perf_fetched !== m_fetched || perf_dropped !== m_dropped || perf_stall !== m_stall) begin
            bad++; $display("FAIL rnd_perf: got %0d/%0d/%0d want %0d/%0d/%0d", perf_fetched, perf_dropped, perf_stall, m_fetched, m_dropped, m_stall);
        end
`endif
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        bus_lat = 0;
        total++; if (perf_fetched !== '0 || perf_dropped !== '0 || perf_stall !== '0) begin bad++; $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", perf_fetched, perf_dropped, perf_stall); end
        repeat (7) tick(1'b0, '0, 1'b0);
        for (int i = 0; i < 20 && m_fetched != 10; i++) tick(1'b0, '0, 1'b1);
        bus_lat = 6;
        for (int i = 0; i < 10 && count != 0; i++) tick(1'b0, '0, 1'b1);
        tick(1'b1, 64'hA000_0000, 1'b0);
        tick(1'b1, 64'hB000_0008, 1'b0);
        for (int i = 0; i < 10 && ireq.valid; i++) tick(1'b0, '0, 1'b0);
        total++; if (perf_fetched !== 64'd10) begin bad++; $display("FAIL perf_fetched: got %0d want 10", perf_fetched); end
        total++; if (perf_dropped !== 64'd1) begin bad++; $display("FAIL perf_dropped: got %0d want 1", perf_dropped); end
        total++; if (perf_stall !== m_stall || m_stall == 0) begin bad++; $display("FAIL perf_stall: got %0d want %0d (nonzero)", perf_stall, m_stall); end
        tick(1'b0, '0, 1'b0);
        total++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'hB000_0008) begin bad++; $display("FAIL perf_next_addr: got %b/%h want 1/B000_0008", ireq.valid, ireq.addr); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_fill_wrap();
        test_redirect_drop();
        test_redirect_dataok();
        test_reset_mid();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
